// File: rtl/bus_split_pkg.sv
// Shared defaults and helpers for the bus width splitter.
// Slice count is derived here so the top and any wrappers agree on RATIO.
package bus_split_pkg;

  localparam int DEF_IN_W  = 64;
  localparam int DEF_OUT_W = 16;
  localparam int DEF_DEPTH = 2;

  function automatic int sliceCount(input int inW, input int outW);
    return inW / outW;
  endfunction

endpackage

// File: rtl/bus_width_splitter_word_fifo.sv
// Word buffer for the splitter: DEPTH-entry circular FIFO with level count.
// Push is ignored when full and pop when empty, so callers may drive raw requests.
module word_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clkB,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         pushData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [WIDTH-1:0]         headData
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (level == LVL_W'(DEPTH));
  assign empty  = (level == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // Head is forced to zero when empty so stale storage never reaches the output.
  assign headData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clkB or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: every read is qualified by a nonzero level.
  always_ff @(posedge clkB) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/bus_width_splitter.sv
// Splits IN_W-bit upstream words into RATIO OUT_W-bit slices, LSB- or MSB-slice first.
// Words are buffered in word_fifo; the slice index lives here and resets per word.
module bus_width_splitter
  import bus_split_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int LSB_FIRST = 1
) (
  input  logic                   clkB,
  input  logic                   reset,
  input  logic [IN_W-1:0]        sharedBus,
  input  logic                   readyA,
  output logic                   acceptedB,
  output logic                   readyB,
  input  logic                   acceptedC,
  output logic [OUT_W-1:0]       sharedBusBC,
  output logic                   lastB,
  output logic [$clog2(DEPTH):0] levelB
);

  localparam int RATIO = sliceCount(IN_W, OUT_W);
  localparam int IDX_W = $clog2(RATIO);

  logic             full;
  logic             empty;
  logic [IN_W-1:0]  headWord;
  logic [IDX_W-1:0] sliceIdx;
  logic [IDX_W-1:0] sliceSel;
  logic             sliceAdv;
  logic             wordPop;

  word_fifo #(
    .WIDTH (IN_W),
    .DEPTH (DEPTH)
  ) uFifo (
    .clkB     (clkB),
    .reset    (reset),
    .push     (readyA),
    .pop      (wordPop),
    .pushData (sharedBus),
    .full     (full),
    .empty    (empty),
    .level    (levelB),
    .headData (headWord)
  );

  assign acceptedB = !full;
  assign readyB    = !empty;
  assign lastB     = readyB && (sliceIdx == IDX_W'(RATIO - 1));
  assign sliceAdv  = readyB && acceptedC;
  assign wordPop   = sliceAdv && lastB;

  assign sliceSel    = (LSB_FIRST != 0) ? sliceIdx : (IDX_W'(RATIO - 1) - sliceIdx);
  assign sharedBusBC = headWord[int'(sliceSel) * OUT_W +: OUT_W];

  always_ff @(posedge clkB or negedge reset) begin
    if (!reset) begin
      sliceIdx <= '0;
    end else if (wordPop) begin
      sliceIdx <= '0;
    end else if (sliceAdv) begin
      sliceIdx <= sliceIdx + IDX_W'(1);
    end
  end

endmodule
